cylon_multi: RTL and testbench
==============================

Name: cylon_multi

Overview:
- Parametrised LED front-panel sequence generator, successor to the fixed 8-bit two-eye cylon.
- Drives WIDTH LEDs in one of four selectable patterns at a selectable rate.
- Adds run/freeze, a one-shot sweep with done flag, a step strobe and a lamp-test phase after reset.
- Sits on the 40 MHz board clock beside the other front-panel LED logic.

Parameters:
- WIDTH, 8: number of LED outputs. Must be even and >= 4; an elaboration-time check rejects other values.
- MXPRE, 21: prescaler width. Benches use 4.
- INIT_DLY, 16: lamp-test length in clocks, >= 1.

Ports:
- clock  in  1  board clock, 40 MHz.
- reset  in  1  asynchronous, active-high.
- rate  in  2  prescaler increment minus 1.
- mode  in  2  0 = single eye, 1 = two eye, 2 = bar fill, 3 = blink.
- run  in  1  1 = advance, 0 = freeze.
- oneshot  in  1  1 = stop after one full sweep.
- q  out  WIDTH  LED pattern, registered.
- step  out  1  one-clock pulse, coincident with each q advance.
- done  out  1  one-shot sweep complete.

Behaviour:
- Reset (async, immediate, including mid-sweep):
  - state = INIT, prescaler p = 0, pos = 0, dir = up.
  - q = 0, step = 0, done = 0, mode_r = mode.
- States: INIT, RUN, DONE.
- INIT:
  - q = all ones (lamp test) for INIT_DLY clocks, counted from the first clock after reset release.
  - Then go to RUN with q = pattern(mode, pos 0).
- Prescaler (RUN only):
  - If run = 1: p <= (p + rate + 1) mod 2^MXPRE.
  - tick = carry out of that add. Period is exactly 2^MXPRE / (rate + 1) for rate 0, 1 and 3; rate 2 gives non-uniform spacing, and that is acceptable.
  - If run = 0: p, pos, dir and q hold; step = 0.
- Sweep limit L by mode:
  - mode 0 and mode 2: L = WIDTH - 1.
  - mode 1: L = WIDTH/2 - 1.
  - mode 3: L = 1.
- Bounce on tick:
  - dir up and pos < L: pos + 1.
  - dir up and pos = L: dir <= down, pos - 1.
  - dir down and pos > 0: pos - 1.
  - dir down and pos = 0: dir <= up, pos + 1.
  - Each endpoint is shown once per sweep; one sweep = 2L ticks.
- Patterns, in bit order WIDTH-1..0:
  - mode 0: bit pos set.
  - mode 1: bits pos and WIDTH-1-pos set.
  - mode 2: bits pos..0 set.
  - mode 3: pos = 1 gives all ones, pos = 0 gives all zeros.
- Output timing:
  - q and step are registered and update on the clock edge that ends the tick cycle (one-clock latency from tick).
  - step is high for exactly that one clock.
- Mode change: when mode != mode_r in RUN or DONE:
  - next clock sets mode_r = mode, pos = 0, dir = up, p = 0, q = pattern(mode, 0), done = 0.
  - state becomes RUN. No step pulse is issued.
  - Mode change takes priority over a coincident tick.
- One-shot:
  - If oneshot = 1 on the tick where dir = down and pos = 1, pos moves to 0 as normal, then state = DONE and done = 1 with the same edge.
  - DONE holds q = pattern(mode_r, 0); p is frozen; no step pulses.
  - DONE to RUN when oneshot = 0 (done clears that edge, p restarts from 0), or on a mode change.
- oneshot asserted mid-sweep takes effect at the current sweep's end. oneshot in INIT is ignored until RUN.
- Widths: pos and L are clog2(WIDTH) bits; p is MXPRE bits. rate + 1 is zero-extended to MXPRE bits.

Decomposition:
- Package cylon_pkg holds:
  - mode constants MODE_ONE, MODE_TWO, MODE_BAR, MODE_BLINK;
  - state encoding for INIT, RUN, DONE;
  - function sweep_limit(mode, WIDTH).
- One sub-module, cylon_decode: combinational (mode, pos) -> WIDTH-bit pattern. It feeds the q register in cylon_multi.

Test Plan (WIDTH=8, MXPRE=4, INIT_DLY=16 unless stated):
- Release reset, mode 0, rate 3, run 1 -> q = FF for 16 clocks, then 01. q then advances every 4 clocks: 02, 04 … 80, 40 … 02, 01. step pulses 14 per sweep, each coincident with a q change.
- mode 1, rate 0 -> q = 81, 42, 24, 18, 24, 42, 81, with each step 16 clocks apart.
- mode 2, rate 1 -> q = 01, 03, 07 … FF, 7F … 01, steps 8 clocks apart. mode 3 -> q alternates FF / 00 each tick.
- oneshot = 1, mode 0 -> after 14 ticks q = 01, done = 1, with no further step for 100 clocks. Deassert oneshot -> done = 0 next clock, then q = 02 after 4 clocks.
- run = 0 at q = 10 for 50 clocks -> q stays 10 and step stays 0. run = 1 -> q = 20 exactly 4 clocks later.
- Change mode 0 to 1 at q = 20 -> next clock q = 81, with no step pulse. Assert reset mid-sweep -> q = 00 before the next clock edge, then the lamp test repeats after release.

Source files
------------

// File: rtl/cylon_pkg.sv
// Shared constants for the front-panel cylon sequence generator.
// Holds the pattern mode codes, the controller state encoding and the
// per-mode sweep limit helper used by both the controller and the decoder.
package cylon_pkg;

    // Pattern modes, as presented on the mode input.
    localparam logic [1:0] MODE_ONE   = 2'd0;  // single eye
    localparam logic [1:0] MODE_TWO   = 2'd1;  // two eyes, mirrored
    localparam logic [1:0] MODE_BAR   = 2'd2;  // bar fill from bit 0
    localparam logic [1:0] MODE_BLINK = 2'd3;  // all on / all off

    // Controller states.
    localparam logic [1:0] ST_INIT = 2'd0;  // lamp test after reset
    localparam logic [1:0] ST_RUN  = 2'd1;  // sweeping
    localparam logic [1:0] ST_DONE = 2'd2;  // one-shot sweep finished

    // Highest position reached by the bouncing index for a given mode.
    // The two-eye pattern only needs to travel to the middle because the
    // second eye mirrors the first; blink just toggles between 0 and 1.
    function automatic int sweep_limit(input logic [1:0] mode, input int width);
        int lim;
        case (mode)
            MODE_ONE, MODE_BAR: lim = width - 1;
            MODE_TWO:           lim = width / 2 - 1;
            default:            lim = 1;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/cylon_decode.sv
// Purpose: maps (mode, pos) to the WIDTH-bit LED pattern.
// Latency: combinational, zero clocks.
// Backpressure: none; pure function of its inputs.
// Ports: mode (pattern select), pos (sweep index), pat (LED pattern out).
module cylon_decode
    import cylon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [1:0]       mode,
    input  logic [PW-1:0]    pos,
    output logic [WIDTH-1:0] pat
);

    always_comb begin
        pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_ONE:  pat[i] = (i == int'(pos));
                MODE_TWO:  pat[i] = (i == int'(pos)) || (i == WIDTH - 1 - int'(pos));
                MODE_BAR:  pat[i] = (i <= int'(pos));
                default:   pat[i] = (pos != '0);
            endcase
        end
    end

endmodule

// File: rtl/cylon_multi.sv
// Purpose: front-panel LED sequence generator: lamp test, then a bouncing
//          pattern (one of four modes) at a prescaled rate, with freeze and
//          one-shot. Latency: q/step register one clock after the tick.
// Backpressure: none; run=0 freezes the sequence in place.
// Ports: clock, reset (async, active-high), rate (increment-1), mode,
//        run, oneshot in; q (LEDs), step (advance strobe), done out.
module cylon_multi
    import cylon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MXPRE    = 21,
    parameter int INIT_DLY = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       rate,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             done
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(INIT_DLY + 1);

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("cylon_multi: WIDTH must be even and at least 4");
        end
        if (INIT_DLY < 1) begin : g_bad_dly
            $error("cylon_multi: INIT_DLY must be at least 1");
        end
    endgenerate

    logic [1:0]       state;
    logic [MXPRE-1:0] p;
    logic [PW-1:0]    pos;
    logic             dir_up;
    logic [1:0]       mode_r;
    logic [CW-1:0]    cnt;

    // Prescaler add; the carry out of the MXPRE-bit accumulator is the tick.
    logic [MXPRE:0] inc;
    logic [MXPRE:0] sum;
    logic           tick;

    assign inc  = (MXPRE + 1)'(rate) + (MXPRE + 1)'(1);
    assign sum  = {1'b0, p} + inc;
    assign tick = run && sum[MXPRE];

    // Bounce: each endpoint is visited once, then the direction flips.
    logic [PW-1:0] lim;
    logic [PW-1:0] nxt_pos;
    logic          nxt_up;

    assign lim = PW'(sweep_limit(mode_r, WIDTH));

    always_comb begin
        nxt_pos = pos;
        nxt_up  = dir_up;
        if (dir_up) begin
            if (pos < lim) begin
                nxt_pos = pos + PW'(1);
            end else begin
                nxt_pos = pos - PW'(1);
                nxt_up  = 1'b0;
            end
        end else begin
            if (pos > '0) begin
                nxt_pos = pos - PW'(1);
            end else begin
                nxt_pos = pos + PW'(1);
                nxt_up  = 1'b1;
            end
        end
    end

    // Mode changes are only honoured once the lamp test is over; in INIT
    // mode_r simply follows the input.
    logic mode_chg;
    assign mode_chg = (state != ST_INIT) && (mode != mode_r);

    // Single decoder shared by every q load: restart loads (INIT exit,
    // mode change) want the new mode at position 0, ticks want the next
    // position under the current mode.
    logic          restart;
    logic [1:0]    dec_mode;
    logic [PW-1:0] dec_pos;
    logic [WIDTH-1:0] pat;

    assign restart  = (state == ST_INIT) || mode_chg;
    assign dec_mode = restart ? mode : mode_r;
    assign dec_pos  = restart ? '0 : nxt_pos;

    cylon_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .mode (dec_mode),
        .pos  (dec_pos),
        .pat  (pat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_INIT;
            p      <= '0;
            pos    <= '0;
            dir_up <= 1'b1;
            q      <= '0;
            step   <= 1'b0;
            done   <= 1'b0;
            mode_r <= mode;
            cnt    <= '0;
        end else begin
            step <= 1'b0;
            if (mode_chg) begin
                // Restart the sweep under the new mode; beats any tick.
                state  <= ST_RUN;
                mode_r <= mode;
                pos    <= '0;
                dir_up <= 1'b1;
                p      <= '0;
                q      <= pat;
                done   <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        mode_r <= mode;
                        if (cnt == CW'(INIT_DLY)) begin
                            state <= ST_RUN;
                            q     <= pat;
                        end else begin
                            cnt <= cnt + CW'(1);
                            q   <= '1;
                        end
                    end
                    ST_RUN: begin
                        if (run) begin
                            p <= sum[MXPRE-1:0];
                            if (tick) begin
                                pos    <= nxt_pos;
                                dir_up <= nxt_up;
                                q      <= pat;
                                step   <= 1'b1;
                                // Last tick of a sweep lands back on 0.
                                if (oneshot && !dir_up && pos == PW'(1)) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!oneshot) begin
                            state <= ST_RUN;
                            done  <= 1'b0;
                            p     <= '0;
                        end
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cylon_multi.sv
// Purpose: self-checking bench for cylon_multi (WIDTH 8, MXPRE 4, INIT_DLY 16).
// Latency: expected q values are queued per tick and popped on each step.
// Backpressure: n/a.
module tb_cylon_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rate = 2'd3;
    logic [1:0] mode = 2'd0;
    logic       run = 1'b1;
    logic       oneshot = 1'b0;
    logic [7:0] q;
    logic       step;
    logic       done;

    cylon_multi #(
        .WIDTH    (8),
        .MXPRE    (4),
        .INIT_DLY (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rate    (rate),
        .mode    (mode),
        .run     (run),
        .oneshot (oneshot),
        .q       (q),
        .step    (step),
        .done    (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_step = -1;
    int steps = 0;
    int exp_gap = 0;
    bit gap_en = 1'b0;
    logic [7:0] sb[$];

    // Bounce model state.
    int m_pos = 0;
    bit m_up = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat8(input int md, input int ps);
        logic [7:0] r;
        case (md)
            0:       r = 8'(1 << ps);
            1:       r = 8'((1 << ps) | (1 << (7 - ps)));
            2:       r = 8'((2 << ps) - 1);
            default: r = (ps != 0) ? 8'hFF : 8'h00;
        endcase
        return r;
    endfunction

    task automatic push_ticks(input int md, input int n);
        int lim;
        lim = (md == 1) ? 3 : (md == 3) ? 1 : 7;
        for (int k = 0; k < n; k++) begin
            if (m_up) begin
                if (m_pos < lim) m_pos++;
                else begin m_up = 1'b0; m_pos--; end
            end else begin
                if (m_pos > 0) m_pos--;
                else begin m_up = 1'b1; m_pos++; end
            end
            sb.push_back(pat8(md, m_pos));
        end
    endtask

    // One clock: sample at the falling edge and score any step.
    task automatic cyc();
        logic [7:0] exp;
        @(negedge clock);
        cycle++;
        if (!gap_en) last_step = -1;
        if (step) begin
            steps++;
            if (sb.size() == 0) begin
                check_val("spurious_step", 32'(step), 32'd0);
            end else begin
                exp = sb.pop_front();
                check_val("step_q", 32'(q), 32'(exp));
            end
            if (gap_en && last_step >= 0)
                check_val("step_gap", 32'(cycle - last_step), 32'(exp_gap));
            last_step = cycle;
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() > 0; i++) cyc();
        check_val("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic change_mode(input logic [1:0] md, input logic [7:0] exp_q);
        mode = md;
        m_pos = 0;
        m_up = 1'b1;
        cyc();
        check_val("mode_chg_q", 32'(q), 32'(exp_q));
        check_val("mode_chg_step", 32'(step), 32'd0);
        check_val("mode_chg_done", 32'(done), 32'd0);
    endtask

    initial begin
        int s0;

        // Reset state.
        #2 reset = 1'b1;
        #1;
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_step", 32'(step), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // Lamp test then mode 0 at rate 3.
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_val("lamp", 32'(q), 32'hFF);
        end
        cyc();
        check_val("init_exit_q", 32'(q), 32'h01);
        check_val("init_exit_step", 32'(step), 32'd0);

        exp_gap = 4;
        gap_en = 1'b1;
        s0 = steps;
        push_ticks(0, 14);
        drain(200);
        check_val("sweep_steps", 32'(steps - s0), 32'd14);

        // Two-eye at rate 0.
        gap_en = 1'b0;
        rate = 2'd0;
        change_mode(2'd1, 8'h81);
        gap_en = 1'b1;
        exp_gap = 16;
        push_ticks(1, 6);
        drain(400);

        // Bar fill at rate 1.
        gap_en = 1'b0;
        rate = 2'd1;
        change_mode(2'd2, 8'h01);
        gap_en = 1'b1;
        exp_gap = 8;
        push_ticks(2, 14);
        drain(400);

        // Blink at rate 3.
        gap_en = 1'b0;
        rate = 2'd3;
        change_mode(2'd3, 8'h00);
        gap_en = 1'b1;
        exp_gap = 4;
        push_ticks(3, 4);
        drain(100);

        // One-shot sweep in mode 0.
        gap_en = 1'b0;
        oneshot = 1'b1;
        change_mode(2'd0, 8'h01);
        push_ticks(0, 14);
        drain(200);
        check_val("oneshot_done", 32'(done), 32'd1);
        check_val("oneshot_q", 32'(q), 32'h01);
        s0 = steps;
        for (int i = 0; i < 100; i++) cyc();
        check_val("done_no_step", 32'(steps - s0), 32'd0);
        check_val("done_hold_q", 32'(q), 32'h01);
        check_val("done_hold", 32'(done), 32'd1);

        oneshot = 1'b0;
        push_ticks(0, 1);
        cyc();
        check_val("done_clear", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("resume_wait_q", 32'(q), 32'h01);
        end
        cyc();
        check_val("resume_q", 32'(q), 32'h02);
        check_val("resume_step", 32'(step), 32'd1);

        // Freeze at q = 10.
        push_ticks(0, 3);
        drain(100);
        check_val("pre_freeze_q", 32'(q), 32'h10);
        run = 1'b0;
        s0 = steps;
        for (int i = 0; i < 50; i++) cyc();
        check_val("freeze_q", 32'(q), 32'h10);
        check_val("freeze_steps", 32'(steps - s0), 32'd0);
        run = 1'b1;
        push_ticks(0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("unfreeze_wait_q", 32'(q), 32'h10);
        end
        cyc();
        check_val("unfreeze_q", 32'(q), 32'h20);

        // Mode change mid-sweep, then reset mid-sweep.
        change_mode(2'd1, 8'h81);
        cyc();
        cyc();
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_q", 32'(q), 32'd0);
        check_val("mid_rst_step", 32'(step), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        run = 1'b0;
        cyc();
        check_val("rst_held_q", 32'(q), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_val("lamp2", 32'(q), 32'hFF);
        end
        cyc();
        check_val("init2_exit_q", 32'(q), 32'h81);
        check_val("init2_exit_step", 32'(step), 32'd0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
